// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbitration of two requesters onto one shared external ALU (IDLE -> EXEC -> RESP).
// Optional feature ALU_ARB_TIMEOUT_EN: an unclaimed response is dropped after TIMEOUT_CYCLES and timeout_err is set.
module alu_arbiter #(
  parameter int WIDTH          = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [3:0]       r0_op,
  output logic             r0_resp_valid,
  input  logic             r0_resp_ready,
  output logic [WIDTH-1:0] r0_result,
  output logic             r0_zero,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [3:0]       r1_op,
  output logic             r1_resp_valid,
  input  logic             r1_resp_ready,
  output logic [WIDTH-1:0] r1_result,
  output logic             r1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic             grant_id,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             ptr;
  logic             grant_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             r0_rv;
  logic             r1_rv;
  logic             any_vld;
  logic             pick;
  logic             hs;

  // Pointer requester wins when it is asking; otherwise the other one gets the slot.
  always_comb begin
    any_vld = r0_valid | r1_valid;
    if (ptr) pick = r1_valid ? 1'b1 : 1'b0;
    else     pick = r0_valid ? 1'b0 : 1'b1;
  end

  assign r0_ready = (state == IDLE) && any_vld && !pick;
  assign r1_ready = (state == IDLE) && any_vld && pick;
  assign hs       = (state == RESP) && (grant_q ? r1_resp_ready : r0_resp_ready);

  assign busy          = (state != IDLE);
  assign grant_id      = grant_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_op        = op_q;
  assign r0_result     = res_q;
  assign r1_result     = res_q;
  assign r0_zero       = zero_q;
  assign r1_zero       = zero_q;
  assign r0_resp_valid = r0_rv;
  assign r1_resp_valid = r1_rv;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          err_q;
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      grant_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      r0_rv   <= 1'b0;
      r1_rv   <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt     <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_vld) begin
            a_q     <= pick ? r1_a  : r0_a;
            b_q     <= pick ? r1_b  : r0_b;
            op_q    <= pick ? r1_op : r0_op;
            grant_q <= pick;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_q  <= alu_result;
          zero_q <= alu_zero;
          r0_rv  <= !grant_q;
          r1_rv  <= grant_q;
          state  <= RESP;
`ifdef ALU_ARB_TIMEOUT_EN
          cnt    <= '0;
`endif
        end
        RESP: begin
          if (hs) begin
            r0_rv <= 1'b0;
            r1_rv <= 1'b0;
            ptr   <= ~grant_q;
            state <= IDLE;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r0_rv <= 1'b0;
            r1_rv <= 1'b0;
            ptr   <= ~grant_q;
            err_q <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction-level reference.
module tb_alu_arbiter;
  localparam int WIDTH = 64;
  localparam int TO    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             r0_valid, r1_valid, r0_ready, r1_ready;
  logic [WIDTH-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [3:0]       r0_op, r1_op;
  logic             r0_resp_valid, r1_resp_valid, r0_resp_ready, r1_resp_ready;
  logic [WIDTH-1:0] r0_result, r1_result;
  logic             r0_zero, r1_zero;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [3:0]       alu_op;
  logic             alu_zero;
  logic             busy, grant_id, timeout_err;

  int tests = 0;
  int fails = 0;

  alu_arbiter #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready),
    .r0_result(r0_result), .r0_zero(r0_zero),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready),
    .r1_result(r1_result), .r1_zero(r1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  // Shared ALU; unlisted opcodes produce XOR so pass-through is observable.
  function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [3:0] op);
    logic [WIDTH-1:0] r;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b1100: r = ~(a | b);
      4'b1110: begin
        r = '0;
        if ($signed(a) < $signed(b)) r[0] = 1'b1;
      end
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);
  assign alu_zero   = (alu_result == '0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    r0_valid = 0; r1_valid = 0; r0_resp_ready = 0; r1_resp_ready = 0;
    r0_a = '0; r0_b = '0; r0_op = '0; r1_a = '0; r1_b = '0; r1_op = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    tick();
    tick();
    tests++;
    if (busy !== 1'b0 || grant_id !== 1'b0) begin
      fails++; $display("FAIL reset_busy_grant: got busy=%b grant=%b, want 0 0", busy, grant_id);
    end
    tests++;
    if ({r0_resp_valid, r1_resp_valid, r0_ready, r1_ready} !== 4'b0) begin
      fails++; $display("FAIL reset_handshakes: got %b, want 0000",
                        {r0_resp_valid, r1_resp_valid, r0_ready, r1_ready});
    end
    tests++;
    if (r0_result !== '0 || r1_zero !== 1'b0 || alu_a !== '0 || alu_b !== '0 || alu_op !== 4'd0) begin
      fails++; $display("FAIL reset_regs: got res=%h zero=%b a=%h b=%h op=%h, want zeros",
                        r0_result, r1_zero, alu_a, alu_b, alu_op);
    end
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++; $display("FAIL reset_timeout_err: got %b, want 0", timeout_err);
    end
    reset_n = 1;
    tick();
  endtask

  task automatic test_single_add();
    r0_valid = 1; r0_a = 64'd5; r0_b = 64'd7; r0_op = 4'b0010; r0_resp_ready = 1;
    #1;
    tests++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      fails++; $display("FAIL add_accept: got r0_ready=%b r1_ready=%b, want 1 0", r0_ready, r1_ready);
    end
    tick();
    r0_valid = 0;
    #1;
    tests++;
    if (busy !== 1'b1 || r0_resp_valid !== 1'b0 || r0_ready !== 1'b0 || alu_a !== 64'd5) begin
      fails++; $display("FAIL add_exec: got busy=%b rv=%b rdy=%b alu_a=%0d, want 1 0 0 5",
                        busy, r0_resp_valid, r0_ready, alu_a);
    end
    tick();
    tests++;
    if (r0_resp_valid !== 1'b1 || r1_resp_valid !== 1'b0 || r0_result !== 64'd12 || r0_zero !== 1'b0) begin
      fails++; $display("FAIL add_resp: got rv0=%b rv1=%b res=%0d zero=%b, want 1 0 12 0",
                        r0_resp_valid, r1_resp_valid, r0_result, r0_zero);
    end
    tick();
    tests++;
    if (r0_resp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL add_done: got rv=%b busy=%b, want 0 0", r0_resp_valid, busy);
    end
    clear_inputs();
  endtask

  task automatic test_both_requesters();
    do_reset();
    r0_valid = 1; r0_a = 64'd9; r0_b = 64'd9; r0_op = 4'b0110;
    r1_valid = 1; r1_a = 64'd3; r1_b = 64'd4; r1_op = 4'b0001;
    r0_resp_ready = 1; r1_resp_ready = 1;
    #1;
    tests++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      fails++; $display("FAIL both_first: got r0_ready=%b r1_ready=%b, want 1 0", r0_ready, r1_ready);
    end
    tick();
    r0_valid = 0;
    tests++;
    if (r1_ready !== 1'b0 || grant_id !== 1'b0) begin
      fails++; $display("FAIL both_wait: got r1_ready=%b grant=%b, want 0 0", r1_ready, grant_id);
    end
    tick();
    tests++;
    if (r0_resp_valid !== 1'b1 || r0_result !== 64'd0 || r0_zero !== 1'b1) begin
      fails++; $display("FAIL both_sub: got rv=%b res=%0d zero=%b, want 1 0 1", r0_resp_valid, r0_result, r0_zero);
    end
    tick();
    tests++;
    if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
      fails++; $display("FAIL both_second: got r1_ready=%b r0_ready=%b, want 1 0", r1_ready, r0_ready);
    end
    tick();
    r1_valid = 0;
    tick();
    tests++;
    if (r1_resp_valid !== 1'b1 || r0_resp_valid !== 1'b0 || r1_result !== 64'd7 || r1_zero !== 1'b0) begin
      fails++; $display("FAIL both_or: got rv1=%b rv0=%b res=%0d zero=%b, want 1 0 7 0",
                        r1_resp_valid, r0_resp_valid, r1_result, r1_zero);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_resp_hold();
    logic [WIDTH-1:0] exp;
    r1_valid = 1; r1_a = 64'hF0F0; r1_b = 64'h0FF0; r1_op = 4'b0000; r1_resp_ready = 0;
    exp = 64'h00F0;
    #1;
    tests++;
    if (r1_ready !== 1'b1) begin
      fails++; $display("FAIL hold_accept: got r1_ready=%b, want 1", r1_ready);
    end
    tick();
    r1_valid = 0;
    r0_valid = 1; r0_a = 64'd100; r0_b = 64'd1; r0_op = 4'b0110;
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (r1_resp_valid !== 1'b1 || r1_result !== exp || r0_ready !== 1'b0) begin
        fails++; $display("FAIL hold_stable[%0d]: got rv=%b res=%h r0_ready=%b, want 1 %h 0",
                          i, r1_resp_valid, r1_result, r0_ready, exp);
      end
      tick();
    end
    r1_resp_ready = 1;
    #1;
    tests++;
    if (r0_ready !== 1'b0) begin
      fails++; $display("FAIL hold_hs_cycle: got r0_ready=%b, want 0", r0_ready);
    end
    tick();
    r1_resp_ready = 0;
    tests++;
    if (r1_resp_valid !== 1'b0 || r0_ready !== 1'b1) begin
      fails++; $display("FAIL hold_after: got rv1=%b r0_ready=%b, want 0 1", r1_resp_valid, r0_ready);
    end
    tick();
    r0_valid = 0; r0_resp_ready = 1;
    tick();
    tests++;
    if (r0_resp_valid !== 1'b1 || r0_result !== 64'd99) begin
      fails++; $display("FAIL hold_r0_result: got rv=%b res=%0d, want 1 99", r0_resp_valid, r0_result);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_in_resp();
    r1_valid = 1; r1_a = 64'd1; r1_b = 64'd2; r1_op = 4'b0010;
    tick();
    r1_valid = 0;
    tick();
    tests++;
    if (r1_resp_valid !== 1'b1) begin
      fails++; $display("FAIL rst_resp_pre: got rv1=%b, want 1", r1_resp_valid);
    end
    reset_n = 0;
    tick();
    tests++;
    if (r0_resp_valid !== 1'b0 || r1_resp_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 1'b0) begin
      fails++; $display("FAIL rst_resp_state: got rv0=%b rv1=%b busy=%b grant=%b, want 0 0 0 0",
                        r0_resp_valid, r1_resp_valid, busy, grant_id);
    end
    reset_n = 1;
    r0_valid = 1; r1_valid = 1; r0_op = 4'b0001; r1_op = 4'b0001;
    #1;
    tests++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      fails++; $display("FAIL rst_resp_ptr: got r0_ready=%b r1_ready=%b, want 1 0", r0_ready, r1_ready);
    end
    tick();
    clear_inputs();
    r0_resp_ready = 1;
    repeat (3) tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    r0_valid = 1; r0_a = 64'd2; r0_b = 64'd3; r0_op = 4'b1110;
    tick();
    r0_valid = 0;
    tick();
    for (int i = 0; i < TO; i++) begin
      tests++;
      if (r0_resp_valid !== 1'b1 || timeout_err !== 1'b0) begin
        fails++; $display("FAIL to_wait[%0d]: got rv=%b err=%b, want 1 0", i, r0_resp_valid, timeout_err);
      end
      tick();
    end
`ifdef ALU_ARB_TIMEOUT_EN
    tests++;
    if (r0_resp_valid !== 1'b0 || timeout_err !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL to_drop: got rv=%b err=%b busy=%b, want 0 1 0", r0_resp_valid, timeout_err, busy);
    end
    tick();
    tests++;
    if (timeout_err !== 1'b1) begin
      fails++; $display("FAIL to_sticky: got err=%b, want 1", timeout_err);
    end
`else
    tests++;
    if (r0_resp_valid !== 1'b1 || timeout_err !== 1'b0 || busy !== 1'b1 || r0_result !== 64'd1) begin
      fails++; $display("FAIL to_nodrop: got rv=%b err=%b busy=%b res=%0d, want 1 0 1 1",
                        r0_resp_valid, timeout_err, busy, r0_result);
    end
`endif
    clear_inputs();
    do_reset();
  endtask

  task automatic test_random();
    logic [3:0]       ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1110, 4'b0101};
    logic             v [2];
    logic             hold [2];
    logic             rr [2];
    logic [WIDTH-1:0] a [2];
    logic [WIDTH-1:0] b [2];
    logic [3:0]       op [2];
    logic             ptr_m, pend, owner, win, any;
    int               acc;
    logic [WIDTH-1:0] exp_res;
    logic             got_rv [2];
    hold[0] = 0; hold[1] = 0;
    ptr_m = 0; pend = 0; owner = 0; acc = 0; exp_res = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!hold[n]) begin
          v[n]  = ($urandom_range(0, 2) != 0);
          a[n]  = {$urandom, $urandom};
          b[n]  = ($urandom_range(0, 3) == 0) ? a[n] : {$urandom, $urandom};
          op[n] = ops[$urandom_range(0, 6)];
          hold[n] = v[n];
        end
        rr[n] = ($urandom_range(0, 1) == 1);
        if (pend && (c - acc) >= 10) rr[n] = 1'b1;
      end
      r0_valid = v[0]; r0_a = a[0]; r0_b = b[0]; r0_op = op[0]; r0_resp_ready = rr[0];
      r1_valid = v[1]; r1_a = a[1]; r1_b = b[1]; r1_op = op[1]; r1_resp_ready = rr[1];
      #1;
      got_rv[0] = r0_resp_valid; got_rv[1] = r1_resp_valid;
      if (pend) begin
        tests++;
        if ({r0_ready, r1_ready} !== 2'b00) begin
          fails++; $display("FAIL rnd_busy_ready c=%0d: got %b, want 00", c, {r0_ready, r1_ready});
        end
        if (c >= acc + 2) begin
          tests++;
          if (got_rv[owner] !== 1'b1 || got_rv[!owner] !== 1'b0) begin
            fails++; $display("FAIL rnd_resp_valid c=%0d: got rv0=%b rv1=%b, want owner %0d only",
                              c, got_rv[0], got_rv[1], owner);
          end
          tests++;
          if (r0_result !== exp_res || r1_result !== exp_res || r0_zero !== (exp_res == '0)) begin
            fails++; $display("FAIL rnd_result c=%0d: got %h zero=%b, want %h zero=%b",
                              c, r0_result, r0_zero, exp_res, (exp_res == '0));
          end
          if (rr[owner]) begin
            pend = 0;
            ptr_m = !owner;
          end
        end else begin
          tests++;
          if (got_rv[0] !== 1'b0 || got_rv[1] !== 1'b0) begin
            fails++; $display("FAIL rnd_early_resp c=%0d: got rv0=%b rv1=%b, want 0 0", c, got_rv[0], got_rv[1]);
          end
        end
      end else begin
        any = v[0] | v[1];
        win = v[ptr_m] ? ptr_m : !ptr_m;
        tests++;
        if (r0_ready !== (any && !win) || r1_ready !== (any && win)) begin
          fails++; $display("FAIL rnd_grant c=%0d: got r0=%b r1=%b, want r0=%b r1=%b",
                            c, r0_ready, r1_ready, any && !win, any && win);
        end
        tests++;
        if (got_rv[0] !== 1'b0 || got_rv[1] !== 1'b0) begin
          fails++; $display("FAIL rnd_idle_resp c=%0d: got rv0=%b rv1=%b, want 0 0", c, got_rv[0], got_rv[1]);
        end
        if (any) begin
          pend = 1; owner = win; acc = c;
          exp_res = alu_f(a[win], b[win], op[win]);
          hold[win] = 0;
        end
      end
      tick();
    end
    clear_inputs();
    r0_resp_ready = 1; r1_resp_ready = 1;
    repeat (4) tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    test_reset();
    test_single_add();
    test_both_requesters();
    test_resp_hold();
    test_reset_in_resp();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
